char_pixel_gen: RTL and testbench

CHAR_PIXEL_GEN -- requirements
Module: char_pixel_gen

---
 rtl/char_pixel_gen.sv | 167 ++++++++++++++++
 tb/tb_char_pixel_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_pixel_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : char_pixel_gen
// Purpose  : Overlays one scaled 8x16 ROM glyph in a fixed box on a video
//            stream; emits a glyph-pixel select aligned with delayed syncs.
// Revision : 1.0
// ============================================================================
module char_pixel_gen #(
    parameter int BOX_X0     = 624,
    parameter int BOX_Y0     = 328,
    parameter int SCALE_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [6:0]  char_code,
    input  logic [23:0] fg_rgb,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        sel,
    output logic [7:0]  char_red,
    output logic [7:0]  char_green,
    output logic [7:0]  char_blue,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [0:0]  c_st_unsynced = 1'b0;
    localparam logic [0:0]  c_st_synced   = 1'b1;

    localparam int          c_box_w = 8 << SCALE_LOG2;
    localparam int          c_box_h = 16 << SCALE_LOG2;

    // Bounds carry one extra bit so a box at the counter limit cannot overflow
    localparam logic [11:0] c_x_lo  = 12'(BOX_X0);
    localparam logic [11:0] c_x_hi  = 12'(BOX_X0 + c_box_w);
    localparam logic [10:0] c_y_lo  = 11'(BOX_Y0);
    localparam logic [10:0] c_y_hi  = 11'(BOX_Y0 + c_box_h);
    localparam logic [10:0] c_x0    = 11'(BOX_X0);
    localparam logic [9:0]  c_y0    = 10'(BOX_Y0);

    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_de_prev;
    logic        r_vs_prev;
    logic [0:0]  r_state;
    logic [6:0]  r_code;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic [10:0] r_rom_addr;
    logic [2:0]  r_col1;
    logic        r_in1;
    logic [2:0]  r_col2;
    logic        r_in2;
    logic        r_sel;
    logic [2:0]  r_de_d;
    logic [2:0]  r_hs_d;
    logic [2:0]  r_vs_d;

    logic        w_vs_rise;
    logic        w_de_fall;
    logic        w_in_box;
    logic [10:0] w_dx;
    logic [9:0]  w_dy;
    logic [2:0]  w_col;
    logic [3:0]  w_row;
    logic        w_pix;

    assign w_vs_rise = vsync_in & ~r_vs_prev;
    assign w_de_fall = r_de_prev & ~de_in;

    assign w_in_box  = de_in
                     & ({1'b0, r_x} >= c_x_lo) & ({1'b0, r_x} < c_x_hi)
                     & ({1'b0, r_y} >= c_y_lo) & ({1'b0, r_y} < c_y_hi);

    assign w_dx  = r_x - c_x0;
    assign w_dy  = r_y - c_y0;
    assign w_col = 3'(w_dx >> SCALE_LOG2);
    assign w_row = 4'(w_dy >> SCALE_LOG2);
    assign w_pix = rom_data[3'd7 - r_col2];

    // Raster position counters; both saturate instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_de_prev <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_de_prev <= de_in;
            r_vs_prev <= vsync_in;
            if (!de_in)
                r_x <= '0;
            else if (r_x != '1)
                r_x <= r_x + 11'd1;
            if (w_vs_rise)
                r_y <= '0;
            else if (w_de_fall && (r_y != '1))
                r_y <= r_y + 10'd1;
        end
    end

    // Frame sync tracking and per-frame latching of glyph code and colour
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_unsynced;
            r_code  <= '0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            case (r_state)
                c_st_unsynced: if (w_vs_rise) r_state <= c_st_synced;
                c_st_synced:   r_state <= c_st_synced;
                default:       r_state <= c_st_unsynced;
            endcase
            if (w_vs_rise) begin
                r_code  <= char_code;
                r_red   <= fg_rgb[23:16];
                r_green <= fg_rgb[15:8];
                r_blue  <= fg_rgb[7:0];
            end
        end
    end

    // Three-stage pixel pipeline; stage 2 waits out the ROM read latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rom_addr <= '0;
            r_col1     <= '0;
            r_in1      <= 1'b0;
            r_col2     <= '0;
            r_in2      <= 1'b0;
            r_sel      <= 1'b0;
            r_de_d     <= '0;
            r_hs_d     <= '0;
            r_vs_d     <= '0;
        end else begin
            if (w_in_box)
                r_rom_addr <= {r_code, w_row};
            r_col1 <= w_col;
            r_in1  <= w_in_box & (r_state == c_st_synced);
            r_col2 <= r_col1;
            r_in2  <= r_in1;
            r_sel  <= r_in2 & w_pix;
            r_de_d <= {r_de_d[1:0], de_in};
            r_hs_d <= {r_hs_d[1:0], hsync_in};
            r_vs_d <= {r_vs_d[1:0], vsync_in};
        end
    end

    assign rom_addr   = r_rom_addr;
    assign sel        = r_sel;
    assign char_red   = r_red;
    assign char_green = r_green;
    assign char_blue  = r_blue;
    assign de_out     = r_de_d[2];
    assign hsync_out  = r_hs_d[2];
    assign vsync_out  = r_vs_d[2];

endmodule
`default_nettype wire

// File: tb/tb_char_pixel_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_char_pixel_gen
// Purpose  : Scoreboard bench for char_pixel_gen with a synchronous ROM model.
// Revision : 1.0
// ============================================================================
module tb_char_pixel_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [6:0]  char_code;
    logic [23:0] fg_rgb;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        sel;
    logic [7:0]  char_red;
    logic [7:0]  char_green;
    logic [7:0]  char_blue;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    logic [7:0]  rom [0:2047];

    typedef struct packed {
        int   line;
        int   col;
        logic de;
        logic hs;
        logic vs;
        logic sel;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_synced;
    bit          m_vs_prev;
    logic [6:0]  m_code;
    int          cur_line;
    int          cur_col;
    bit          g_mid_change;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    char_pixel_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .de_in      (de_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .char_code  (char_code),
        .fg_rgb     (fg_rgb),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sel        (sel),
        .char_red   (char_red),
        .char_green (char_green),
        .char_blue  (char_blue),
        .de_out     (de_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected glyph pixel from the bench's own raster position
    function automatic logic model_sel(input int line, input int col);
        int          cs;
        int          bit_idx;
        logic [10:0] a;
        logic [7:0]  r;
        cs = (col > 2047) ? 2047 : col;
        if (line < 328 || line >= 392 || cs < 624 || cs >= 656)
            return 1'b0;
        a       = {m_code, 4'((line - 328) >> 2)};
        r       = rom[a];
        bit_idx = 7 - ((cs - 624) >> 2);
        return r[bit_idx];
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (q.size() >= 3) begin
            e = q.pop_front();
            check($sformatf("pipe L%0d C%0d", e.line, e.col),
                  {28'b0, de_out, hsync_out, vsync_out, sel},
                  {28'b0, e.de, e.hs, e.vs, e.sel});
        end
    endtask

    task automatic step(input logic de, input logic hs, input logic vs);
        exp_t e;
        reset_n  = 1'b1;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        e.line = cur_line;
        e.col  = cur_col;
        e.de   = de;
        e.hs   = hs;
        e.vs   = vs;
        e.sel  = de && m_synced && model_sel(cur_line, cur_col);
        if (vs && !m_vs_prev) begin
            m_synced = 1'b1;
            m_code   = char_code;
        end
        m_vs_prev = vs;
        q.push_back(e);
        tick();
    endtask

    // Reset flushes the pipeline: the next three outputs are all zero
    task automatic reset_step();
        exp_t z;
        z        = '0;
        z.line   = -1;
        reset_n  = 1'b0;
        de_in    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        q.delete();
        repeat (3) q.push_back(z);
        m_synced  = 1'b0;
        m_vs_prev = 1'b0;
        tick();
    endtask

    task automatic frame(input int full_lo, input int full_hi, input int extra_line,
                         input int long_line, input bit tight, input int rst_line,
                         input logic [23:0] exp_rgb);
        int w;
        if (tight) begin
            cur_line = 999;
            for (int c = 0; c < 3; c++) begin
                cur_col = c;
                step(1'b1, 1'b0, 1'b0);
            end
        end
        cur_col = 0;
        repeat (4) step(1'b0, 1'b0, 1'b1);
        check("rgb_latch", {8'b0, char_red, char_green, char_blue}, {8'b0, exp_rgb});
        repeat (4) step(1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 394; l++) begin
            cur_line = l;
            w = ((l >= full_lo && l <= full_hi) || l == extra_line) ? 660 : 2;
            if (l == long_line)
                w = 2700;
            for (int c = 0; c < w; c++) begin
                cur_col = c;
                if (g_mid_change && l == 340 && c == 0) begin
                    fg_rgb    = 24'h00FF00;
                    char_code = 7'h42;
                end
                if (l == rst_line && c == 630) begin
                    reset_step();
                    reset_step();
                end
                step(1'b1, 1'b0, 1'b0);
                if (l == extra_line && c == 624 && m_synced)
                    check("rom_addr", {21'b0, rom_addr}, {21'b0, m_code, 4'((l - 328) >> 2)});
            end
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL timeout: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        de_in        = 1'b0;
        hsync_in     = 1'b0;
        vsync_in     = 1'b0;
        char_code    = '0;
        fg_rgb       = '0;
        m_synced     = 1'b0;
        m_vs_prev    = 1'b0;
        m_code       = '0;
        cur_line     = 999;
        cur_col      = 0;
        g_mid_change = 1'b0;
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        rom[11'h410] = 8'h80;

        @(negedge clk);
        repeat (4) reset_step();
        check("rst_sel",  {31'b0, sel}, 32'd0);
        check("rst_sync", {29'b0, de_out, hsync_out, vsync_out}, 32'd0);
        check("rst_addr", {21'b0, rom_addr}, 32'd0);
        check("rst_rgb",  {8'b0, char_red, char_green, char_blue}, 32'd0);

        // Arbitrary sync/enable pattern away from the box
        cur_line = 999;
        for (int i = 0; i < 200; i++) begin
            cur_col = i;
            step(1'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (4) step(1'b0, 1'b0, 1'b0);

        // Glyph 0x41, row 0 = 0x80, saturating x on line 330, mid-frame changes
        char_code    = 7'h41;
        fg_rgb       = 24'hFF8000;
        g_mid_change = 1'b1;
        frame(327, 328, 348, 330, 1'b0, -1, 24'hFF8000);
        g_mid_change = 1'b0;
        check("rgb_hold", {8'b0, char_red, char_green, char_blue}, 32'h00FF8000);

        // Solid ROM: full box rectangle; vsync rises on the de fall
        for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
        frame(327, 392, -1, -1, 1'b1, -1, 24'h00FF00);

        // Reset mid-box: select stays low for the rest of the frame
        frame(328, 329, -1, -1, 1'b0, 328, 24'h00FF00);
        check("rgb_rst",  {8'b0, char_red, char_green, char_blue}, 32'd0);
        check("addr_rst", {21'b0, rom_addr}, 32'd0);

        // Following frame renders normally again
        frame(327, 330, 360, -1, 1'b0, -1, 24'h00FF00);

        cur_line = 999;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
